// File: rtl/syn_update_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : syn_update_seq                                                  |
// | Purpose  : Training-phase sequencer placed in front of synaptic_core.      |
// |            After each sample it sweeps the synaptic array row by row.      |
// |            For every row it fetches the pre-neuron spike count, then does  |
// |            a read / write-back pair for every packed weight word in the    |
// |            row. The write cycle carries the FFSTDP update enable.          |
// | Ports    : CLK, RST_N (async, active low)                                  |
// |            START / IS_TRAIN            - sweep request (IS_TRAIN sampled    |
// |                                          together with START)              |
// |            PRE_NEUR_S_CNT_RD           - pre-neuron memory read data        |
// |            CTRL_PRE_NEUR_CS/_ADDR      - pre-neuron memory read port        |
// |            PRE_NEUR_S_CNT              - registered count of current row    |
// |            CTRL_SYNARRAY_CS/_WE/_ADDR  - synaptic SRAM port                 |
// |            CTRL_POST_NEURON_ADDRESS    - first post-neuron of current word  |
// |            CTRL_TREF_EVENT             - update enable (write cycles only)  |
// |            BUSY, DONE                  - status                             |
// | Options  : SKIP_ZERO_PRE_EN - when defined, a row whose pre-neuron count   |
// |            is zero is skipped without any synaptic access.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module syn_update_seq #(
   parameter int INPUT_NEURON         = 784,
   parameter int OUTPUT_NEURON        = 256,
   parameter int POST_NEUR_PARALLEL   = 4,
   parameter int PRE_NEUR_ADDR_WIDTH  = 10,
   parameter int POST_NEUR_ADDR_WIDTH = 10,
   parameter int PRE_NEUR_DATA_WIDTH  = 8,
   parameter int SYN_ARRAY_ADDR_WIDTH = 16
) (
   input  logic                            CLK,
   input  logic                            RST_N,
   input  logic                            START,
   input  logic                            IS_TRAIN,
   input  logic [PRE_NEUR_DATA_WIDTH-1:0]  PRE_NEUR_S_CNT_RD,
   output logic                            CTRL_PRE_NEUR_CS,
   output logic [PRE_NEUR_ADDR_WIDTH-1:0]  CTRL_PRE_NEUR_ADDR,
   output logic [PRE_NEUR_DATA_WIDTH-1:0]  PRE_NEUR_S_CNT,
   output logic                            CTRL_SYNARRAY_CS,
   output logic                            CTRL_SYNARRAY_WE,
   output logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_SYNARRAY_ADDR,
   output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
   output logic                            CTRL_TREF_EVENT,
   output logic                            BUSY,
   output logic                            DONE
);

   localparam int WORDS_PER_ROW = OUTPUT_NEURON / POST_NEUR_PARALLEL;
   localparam int WORD_W        = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

   localparam logic [PRE_NEUR_ADDR_WIDTH-1:0] LAST_ROW  = PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1);
   localparam logic [WORD_W-1:0]              LAST_WORD = WORD_W'(WORDS_PER_ROW - 1);
   localparam logic [PRE_NEUR_ADDR_WIDTH-1:0] ROW_ONE   = PRE_NEUR_ADDR_WIDTH'(1);
   localparam logic [WORD_W-1:0]              WORD_ONE  = WORD_W'(1);

   localparam logic [63:0] SYN_WORDS = 64'(INPUT_NEURON) * 64'(WORDS_PER_ROW);
   localparam logic [63:0] SYN_SPACE = 64'd1 << SYN_ARRAY_ADDR_WIDTH;

   // The whole array must be addressable without wrap-around.
   if (SYN_WORDS > SYN_SPACE) begin : g_syn_addr_space_check
      $error("syn_update_seq: INPUT_NEURON*WORDS_PER_ROW exceeds synaptic address space");
   end

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PRE_RD  = 3'd1,
      ST_PRE_CHK = 3'd2,
      ST_SYN_RD  = 3'd3,
      ST_SYN_WR  = 3'd4,
      ST_FIN     = 3'd5
   } state_t;

   state_t                           state_q, state_d;
   logic [PRE_NEUR_ADDR_WIDTH-1:0]   row_q,   row_d;
   logic [WORD_W-1:0]                word_q,  word_d;
   logic [PRE_NEUR_DATA_WIDTH-1:0]   cnt_q,   cnt_d;

   logic [SYN_ARRAY_ADDR_WIDTH-1:0]  syn_addr;
   logic [POST_NEUR_ADDR_WIDTH-1:0]  post_addr;

   // Full-width address arithmetic: operands are widened before the multiply.
   assign syn_addr  = SYN_ARRAY_ADDR_WIDTH'(row_q) * SYN_ARRAY_ADDR_WIDTH'(WORDS_PER_ROW)
                    + SYN_ARRAY_ADDR_WIDTH'(word_q);
   assign post_addr = POST_NEUR_ADDR_WIDTH'(word_q) * POST_NEUR_ADDR_WIDTH'(POST_NEUR_PARALLEL);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         word_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               if (IS_TRAIN) begin
                  row_d   = '0;
                  word_d  = '0;
                  state_d = ST_PRE_RD;
               end else begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_PRE_RD: begin
            state_d = ST_PRE_CHK;
         end
         ST_PRE_CHK: begin
            // Read data from the PRE_RD request is valid in this cycle.
            cnt_d   = PRE_NEUR_S_CNT_RD;
            state_d = ST_SYN_RD;
`ifdef SKIP_ZERO_PRE_EN
            if (PRE_NEUR_S_CNT_RD == '0) begin
               if (row_q == LAST_ROW) begin
                  state_d = ST_FIN;
               end else begin
                  row_d   = row_q + ROW_ONE;
                  state_d = ST_PRE_RD;
               end
            end
`endif
         end
         ST_SYN_RD: begin
            state_d = ST_SYN_WR;
         end
         ST_SYN_WR: begin
            if (word_q != LAST_WORD) begin
               word_d  = word_q + WORD_ONE;
               state_d = ST_SYN_RD;
            end else if (row_q != LAST_ROW) begin
               word_d  = '0;
               row_d   = row_q + ROW_ONE;
               state_d = ST_PRE_RD;
            end else begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decode only registered state, so START never reaches an output
   // combinationally; addresses are forced to zero outside their states.
   always_comb begin
      CTRL_PRE_NEUR_CS         = 1'b0;
      CTRL_PRE_NEUR_ADDR       = '0;
      CTRL_SYNARRAY_CS         = 1'b0;
      CTRL_SYNARRAY_WE         = 1'b0;
      CTRL_SYNARRAY_ADDR       = '0;
      CTRL_POST_NEURON_ADDRESS = '0;
      CTRL_TREF_EVENT          = 1'b0;
      BUSY                     = 1'b0;
      DONE                     = 1'b0;
      case (state_q)
         ST_PRE_RD: begin
            CTRL_PRE_NEUR_CS   = 1'b1;
            CTRL_PRE_NEUR_ADDR = row_q;
            BUSY               = 1'b1;
         end
         ST_PRE_CHK: begin
            BUSY = 1'b1;
         end
         ST_SYN_RD: begin
            CTRL_SYNARRAY_CS         = 1'b1;
            CTRL_SYNARRAY_ADDR       = syn_addr;
            CTRL_POST_NEURON_ADDRESS = post_addr;
            BUSY                     = 1'b1;
         end
         ST_SYN_WR: begin
            // SRAM output still holds the SYN_RD word; the updated value of
            // that word is written back to the same address.
            CTRL_SYNARRAY_CS   = 1'b1;
            CTRL_SYNARRAY_WE   = 1'b1;
            CTRL_SYNARRAY_ADDR = syn_addr;
            CTRL_TREF_EVENT    = 1'b1;
            BUSY               = 1'b1;
         end
         ST_FIN: begin
            DONE = 1'b1;
         end
         default: begin
            BUSY = 1'b0;
         end
      endcase
   end

   assign PRE_NEUR_S_CNT = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_syn_update_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_syn_update_seq                                               |
// | Purpose  : Self-checking bench for syn_update_seq (4 rows, 2 words/row).   |
// |            Expected access lists and latencies come from a row-level       |
// |            model of the sweep.                                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_syn_update_seq;

   localparam int IN_N = 4;
   localparam int OUT_N = 8;
   localparam int PAR = 4;
   localparam int W = OUT_N / PAR;
   localparam int PAW = 10;
   localparam int POAW = 10;
   localparam int PDW = 8;
   localparam int SAW = 16;
   localparam int BUDGET = 200;

`ifdef SKIP_ZERO_PRE_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct packed {
      logic [SAW-1:0] addr;
      logic           we;
   } acc_t;

   logic            CLK = 1'b0;
   logic            RST_N = 1'b0;
   logic            START = 1'b0;
   logic            IS_TRAIN = 1'b0;
   logic [PDW-1:0]  pre_rd_data = '0;
   logic            CTRL_PRE_NEUR_CS;
   logic [PAW-1:0]  CTRL_PRE_NEUR_ADDR;
   logic [PDW-1:0]  PRE_NEUR_S_CNT;
   logic            CTRL_SYNARRAY_CS;
   logic            CTRL_SYNARRAY_WE;
   logic [SAW-1:0]  CTRL_SYNARRAY_ADDR;
   logic [POAW-1:0] CTRL_POST_NEURON_ADDRESS;
   logic            CTRL_TREF_EVENT;
   logic            BUSY;
   logic            DONE;

   int n_tests = 0;
   int n_fail  = 0;

   logic [PDW-1:0] pre_mem [IN_N];

   syn_update_seq #(
      .INPUT_NEURON(IN_N), .OUTPUT_NEURON(OUT_N), .POST_NEUR_PARALLEL(PAR),
      .PRE_NEUR_ADDR_WIDTH(PAW), .POST_NEUR_ADDR_WIDTH(POAW),
      .PRE_NEUR_DATA_WIDTH(PDW), .SYN_ARRAY_ADDR_WIDTH(SAW)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .IS_TRAIN(IS_TRAIN),
      .PRE_NEUR_S_CNT_RD(pre_rd_data),
      .CTRL_PRE_NEUR_CS(CTRL_PRE_NEUR_CS), .CTRL_PRE_NEUR_ADDR(CTRL_PRE_NEUR_ADDR),
      .PRE_NEUR_S_CNT(PRE_NEUR_S_CNT),
      .CTRL_SYNARRAY_CS(CTRL_SYNARRAY_CS), .CTRL_SYNARRAY_WE(CTRL_SYNARRAY_WE),
      .CTRL_SYNARRAY_ADDR(CTRL_SYNARRAY_ADDR),
      .CTRL_POST_NEURON_ADDRESS(CTRL_POST_NEURON_ADDRESS),
      .CTRL_TREF_EVENT(CTRL_TREF_EVENT), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   // Pre-neuron memory: one-cycle synchronous read.
   always @(posedge CLK) begin
      if (CTRL_PRE_NEUR_CS) pre_rd_data <= pre_mem[CTRL_PRE_NEUR_ADDR[1:0]];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {14'd0, CTRL_PRE_NEUR_CS, CTRL_PRE_NEUR_ADDR, PRE_NEUR_S_CNT,
              CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_SYNARRAY_ADDR,
              CTRL_POST_NEURON_ADDRESS, CTRL_TREF_EVENT, BUSY, DONE};
   endfunction

   task automatic run_sweep(input bit train, input bit extra_starts, input string name);
      acc_t exp_q[$];
      acc_t got_q[$];
      int   exp_pre[$];
      int   got_pre[$];
      int   lat, done_at, busy_cnt, viol, exp_busy;
      acc_t got_a;

      // Reference: cost per row and the access list from the sweep rules.
      lat = 1;
      if (train) begin
         for (int r = 0; r < IN_N; r++) begin
            exp_pre.push_back(r);
            if (SKIP && pre_mem[r] == 0) begin
               lat += 2;
            end else begin
               lat += 2 + 2 * W;
               for (int w = 0; w < W; w++) begin
                  exp_q.push_back(acc_t'{addr: SAW'(r * W + w), we: 1'b0});
                  exp_q.push_back(acc_t'{addr: SAW'(r * W + w), we: 1'b1});
               end
            end
         end
      end
      exp_busy = train ? lat - 1 : 0;

      @(negedge CLK);
      START    = 1'b1;
      IS_TRAIN = train;
      @(negedge CLK);
      START    = 1'b0;
      IS_TRAIN = 1'($urandom);

      done_at  = 0;
      busy_cnt = 0;
      viol     = 0;
      for (int m = 1; m <= BUDGET && done_at == 0; m++) begin
         if (m > 1) @(negedge CLK);
         if (BUSY) busy_cnt++;
         if (DONE) done_at = m;
         if (BUSY && DONE) viol++;
         if (CTRL_PRE_NEUR_CS) got_pre.push_back(int'(CTRL_PRE_NEUR_ADDR));
         else if (CTRL_PRE_NEUR_ADDR !== '0) viol++;
         if (CTRL_SYNARRAY_CS) begin
            got_q.push_back(acc_t'{addr: CTRL_SYNARRAY_ADDR, we: CTRL_SYNARRAY_WE});
            if (CTRL_TREF_EVENT !== CTRL_SYNARRAY_WE) viol++;
            if (!CTRL_SYNARRAY_WE &&
                int'(CTRL_POST_NEURON_ADDRESS) != (int'(CTRL_SYNARRAY_ADDR) % W) * PAR) viol++;
            if (CTRL_SYNARRAY_WE &&
                PRE_NEUR_S_CNT !== pre_mem[(int'(CTRL_SYNARRAY_ADDR) / W) % IN_N]) viol++;
         end else if (CTRL_SYNARRAY_ADDR !== '0 || CTRL_SYNARRAY_WE !== 1'b0 ||
                      CTRL_TREF_EVENT !== 1'b0 || CTRL_POST_NEURON_ADDRESS !== '0) begin
            viol++;
         end
         if (extra_starts && done_at == 0) begin
            START    = ($urandom_range(0, 3) == 0);
            IS_TRAIN = 1'($urandom);
         end
      end
      START = 1'b0;

      chk({name, "_done_cycle"}, 64'(done_at), 64'(lat));
      chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
      chk({name, "_protocol_viol"}, 64'(viol), 64'd0);
      chk({name, "_num_access"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         got_a = (i < got_q.size()) ? got_q[i] : '1;
         chk({name, "_access"}, 64'(got_a), 64'(exp_q[i]));
      end
      chk({name, "_num_pre_rd"}, 64'(got_pre.size()), 64'(exp_pre.size()));
      for (int i = 0; i < exp_pre.size() && i < got_pre.size(); i++) begin
         chk({name, "_pre_addr"}, 64'(got_pre[i]), 64'(exp_pre[i]));
      end

      // Sequencer must be back in idle with a single DONE.
      for (int j = 0; j < 3; j++) begin
         @(negedge CLK);
         chk({name, "_after_idle"},
             {60'd0, DONE, BUSY, CTRL_SYNARRAY_CS, CTRL_PRE_NEUR_CS}, 64'd0);
      end
   endtask

   initial begin
      bit tr, ex;
      for (int r = 0; r < IN_N; r++) pre_mem[r] = 8'd5;

      // Reset and idle.
      repeat (3) @(negedge CLK);
      chk("reset_outs", all_outs(), 64'd0);
      RST_N = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         chk("idle_outs", all_outs(), 64'd0);
      end

      run_sweep(1'b1, 1'b0, "all5");
      run_sweep(1'b0, 1'b0, "untrained");

      pre_mem[0] = 8'd3; pre_mem[1] = 8'd0; pre_mem[2] = 8'd0; pre_mem[3] = 8'd7;
      run_sweep(1'b1, 1'b0, "skipmix");

      for (int r = 0; r < IN_N; r++) pre_mem[r] = 8'd5;
      run_sweep(1'b1, 1'b1, "extra_start");
      run_sweep(1'b0, 1'b1, "untrained_extra");

      // Reset asserted in the middle of a sweep.
      @(negedge CLK);
      START = 1'b1; IS_TRAIN = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (9) @(negedge CLK);
      chk("busy_before_rst", {63'd0, BUSY}, 64'd1);
      #2 RST_N = 1'b0;
      #1 chk("rst_async_outs", all_outs(), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("rst_hold_outs", all_outs(), 64'd0);
      end
      RST_N = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("post_rst_idle", all_outs(), 64'd0);
      end
      run_sweep(1'b1, 1'b0, "after_rst");

      // Randomized sweeps.
      for (int t = 0; t < 10; t++) begin
         for (int r = 0; r < IN_N; r++)
            pre_mem[r] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         tr = ($urandom_range(0, 3) != 0);
         ex = 1'($urandom_range(0, 1));
         run_sweep(tr, ex, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
